// File: rtl/xsim_msg_deframer.sv
// xsim_msg_deframer
// Consumes the simulator sink's beat stream (no backpressure), parses the
// portal header beat, gathers payload words into an assembly buffer and
// presents each whole message in a held output register with valid/ready.
// Messages that complete while the output register is still occupied are
// dropped and flagged through the sticky overflow bit.

module xsim_msg_deframer #(
    parameter int MAX_WORDS = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    beat_valid,
    input  logic [31:0]             beat,
    output logic                    msg_valid,
    input  logic                    msg_ready,
    output logic [15:0]             msg_method,
    output logic [15:0]             msg_nwords,
    output logic [MAX_WORDS*32-1:0] msg_data,
    output logic                    busy,
    output logic                    overflow,
    output logic                    bad_len
);

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // Longest legal header length: payload words plus the header beat itself.
    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS + 1);

    // Assembly side
    state_t                        state_q, state_d;
    logic [15:0]                   idx_q, idx_d;
    logic [15:0]                   rem_q, rem_d;
    logic [15:0]                   meth_q, meth_d;
    logic [15:0]                   nw_q, nw_d;
    logic [MAX_WORDS-1:0][31:0]    buf_q, buf_d;
    logic                          bad_len_q, bad_len_d;

    // Output register side
    logic                          valid_q, valid_d;
    logic [15:0]                   out_meth_q, out_meth_d;
    logic [15:0]                   out_nw_q, out_nw_d;
    logic [MAX_WORDS-1:0][31:0]    out_data_q, out_data_d;
    logic                          overflow_q, overflow_d;

    // Completion bundle handed from the parser to the output register
    logic                          complete_s;
    logic [15:0]                   cmp_method_s;
    logic [15:0]                   cmp_nwords_s;
    logic [MAX_WORDS-1:0][31:0]    cmp_data_s;
    logic [15:0]                   hdr_len_s;
    logic                          load_ok_s;

    assign hdr_len_s = beat[15:0];
    // The output register may take a new message when empty or draining this cycle.
    assign load_ok_s = !valid_q || msg_ready;

    // Header parse, payload gather and discard sequencing; state moves only on beats.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rem_d        = rem_q;
        meth_d       = meth_q;
        nw_d         = nw_q;
        buf_d        = buf_q;
        bad_len_d    = bad_len_q;
        complete_s   = 1'b0;
        cmp_method_s = meth_q;
        cmp_nwords_s = nw_q;
        cmp_data_s   = buf_q;
        if (beat_valid) begin
            case (state_q)
                ST_HDR: begin
                    if (hdr_len_s == 16'd0) begin
                        bad_len_d = 1'b1;
                    end else if (hdr_len_s == 16'd1) begin
                        // Header-only message: completes on this very beat.
                        complete_s   = 1'b1;
                        cmp_method_s = beat[31:16];
                        cmp_nwords_s = 16'd0;
                        cmp_data_s   = '0;
                    end else if ({1'b0, hdr_len_s} <= MAX_LEN) begin
                        meth_d  = beat[31:16];
                        nw_d    = hdr_len_s - 16'd1;
                        rem_d   = hdr_len_s - 16'd1;
                        idx_d   = 16'd0;
                        buf_d   = '0;
                        state_d = ST_PAYLOAD;
                    end else begin
                        // Too long to hold: swallow the payload beats without storing.
                        bad_len_d = 1'b1;
                        rem_d     = hdr_len_s - 16'd1;
                        state_d   = ST_DISCARD;
                    end
                end
                ST_PAYLOAD: begin
                    for (int i = 0; i < MAX_WORDS; i++) begin
                        if (idx_q == 16'(i)) begin
                            buf_d[i] = beat;
                        end else begin
                            buf_d[i] = buf_q[i];
                        end
                    end
                    idx_d = idx_q + 16'd1;
                    if (rem_q != 16'd0) begin
                        rem_d = rem_q - 16'd1;
                    end else begin
                        rem_d = rem_q;
                    end
                    if (rem_q <= 16'd1) begin
                        // Last payload beat: the message includes the word written now.
                        complete_s = 1'b1;
                        cmp_data_s = buf_d;
                        state_d    = ST_HDR;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_DISCARD: begin
                    if (rem_q != 16'd0) begin
                        rem_d = rem_q - 16'd1;
                    end else begin
                        rem_d = rem_q;
                    end
                    if (rem_q <= 16'd1) begin
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
                default: begin
                    state_d = ST_HDR;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output register: load, drop with overflow, or drain on handshake.
    always_comb begin
        valid_d    = valid_q;
        out_meth_d = out_meth_q;
        out_nw_d   = out_nw_q;
        out_data_d = out_data_q;
        overflow_d = overflow_q;
        if (complete_s && load_ok_s) begin
            valid_d    = 1'b1;
            out_meth_d = cmp_method_s;
            out_nw_d   = cmp_nwords_s;
            out_data_d = cmp_data_s;
        end else if (complete_s) begin
            overflow_d = 1'b1;
        end else if (valid_q && msg_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= ST_HDR;
            idx_q      <= 16'd0;
            rem_q      <= 16'd0;
            meth_q     <= 16'd0;
            nw_q       <= 16'd0;
            buf_q      <= '0;
            bad_len_q  <= 1'b0;
            valid_q    <= 1'b0;
            out_meth_q <= 16'd0;
            out_nw_q   <= 16'd0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            meth_q     <= meth_d;
            nw_q       <= nw_d;
            buf_q      <= buf_d;
            bad_len_q  <= bad_len_d;
            valid_q    <= valid_d;
            out_meth_q <= out_meth_d;
            out_nw_q   <= out_nw_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign msg_valid  = valid_q;
    assign msg_method = out_meth_q;
    assign msg_nwords = out_nw_q;
    assign msg_data   = out_data_q;
    assign busy       = (state_q != ST_HDR);
    assign overflow   = overflow_q;
    assign bad_len    = bad_len_q;

endmodule

// File: tb/tb_xsim_msg_deframer.sv
// Directed bench for xsim_msg_deframer: a per-cycle vector table for the
// common message flows, plus hand sequences for reset, the maximum legal
// length and oversize discards.

module tb_xsim_msg_deframer;

    localparam int MW = 16;
    localparam int DW = MW * 32;

    logic          CLK;
    logic          RST;
    logic          beat_valid;
    logic [31:0]   beat;
    logic          msg_valid;
    logic          msg_ready;
    logic [15:0]   msg_method;
    logic [15:0]   msg_nwords;
    logic [DW-1:0] msg_data;
    logic          busy;
    logic          overflow;
    logic          bad_len;

    int checks   = 0;
    int failures = 0;

    xsim_msg_deframer #(.MAX_WORDS(MW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .beat_valid (beat_valid),
        .beat       (beat),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_method (msg_method),
        .msg_nwords (msg_nwords),
        .msg_data   (msg_data),
        .busy       (busy),
        .overflow   (overflow),
        .bad_len    (bad_len)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        bv;
        logic [31:0] b;
        logic        rdy;
        logic        ev;
        logic [15:0] em;
        logic [15:0] en;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        eb;
        logic        eo;
        logic        el;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic bv, input logic [31:0] b, input logic rdy,
                       input logic ev, input logic [15:0] em, input logic [15:0] en,
                       input logic [31:0] w0, input logic [31:0] w1,
                       input logic eb, input logic eo, input logic el);
        vec_t v;
        v.bv = bv; v.b = b; v.rdy = rdy; v.ev = ev; v.em = em; v.en = en;
        v.w0 = w0; v.w1 = w1; v.eb = eb; v.eo = eo; v.el = el;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs and sample the registered result after the edge.
    task automatic step(input logic bv, input logic [31:0] b, input logic rdy);
        beat_valid = bv;
        beat       = b;
        msg_ready  = rdy;
        @(posedge CLK);
        #1;
    endtask

    // Compare all outputs; message fields only when a message is expected
    // or when full is set (reset: everything must read zero).
    task automatic check_out(input string nm, input logic ev, input logic [15:0] em,
                             input logic [15:0] en, input logic [DW-1:0] ed,
                             input logic eb, input logic eo, input logic el,
                             input bit full);
        chk({nm, "_valid"}, DW'(msg_valid), DW'(ev));
        chk({nm, "_busy"}, DW'(busy), DW'(eb));
        chk({nm, "_overflow"}, DW'(overflow), DW'(eo));
        chk({nm, "_bad_len"}, DW'(bad_len), DW'(el));
        if (ev || full) begin
            chk({nm, "_method"}, DW'(msg_method), DW'(em));
            chk({nm, "_nwords"}, DW'(msg_nwords), DW'(en));
            chk({nm, "_data"}, msg_data, ed);
        end
    endtask

    initial begin
        logic [DW-1:0] ed;

        // ---------------- vector table ----------------
        // Test 1: 3-beat message, ready high
        add(1'b1, 32'h0005_0003, 1'b1, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 32'h0000_000A, 1'b1, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 32'h0000_000B, 1'b1, 1'b1, 16'd5, 16'd2, 32'hA, 32'hB, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,         1'b1, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        // Test 2: header-only messages; second one lands during the drain of the first
        add(1'b1, 32'h0007_0001, 1'b1, 1'b1, 16'd7, 16'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 32'h0009_0001, 1'b1, 1'b1, 16'd9, 16'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,         1'b1, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        // Test 3a: two 2-word messages back-to-back, ready high
        add(1'b1, 32'h0003_0003, 1'b1, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 32'h0000_0011, 1'b1, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 32'h0000_0022, 1'b1, 1'b1, 16'd3, 16'd2, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0);
        add(1'b1, 32'h0004_0003, 1'b1, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 32'h0000_0033, 1'b1, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 32'h0000_0044, 1'b1, 1'b1, 16'd4, 16'd2, 32'h33, 32'h44, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,         1'b1, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        // Test 3b: same with ready low -> first held, second dropped, overflow
        add(1'b1, 32'h0003_0003, 1'b0, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 32'h0000_0011, 1'b0, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 32'h0000_0022, 1'b0, 1'b1, 16'd3, 16'd2, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0);
        add(1'b1, 32'h0004_0003, 1'b0, 1'b1, 16'd3, 16'd2, 32'h11, 32'h22, 1'b1, 1'b0, 1'b0);
        add(1'b1, 32'h0000_0033, 1'b0, 1'b1, 16'd3, 16'd2, 32'h11, 32'h22, 1'b1, 1'b0, 1'b0);
        add(1'b1, 32'h0000_0044, 1'b0, 1'b1, 16'd3, 16'd2, 32'h11, 32'h22, 1'b0, 1'b1, 1'b0);
        // Test 3c: ready high delivers the held first message
        add(1'b0, 32'h0,         1'b1, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        // Test 5: gaps inside the payload give the same result as test 1
        add(1'b1, 32'h0005_0003, 1'b1, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 32'h0000_000A, 1'b1, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 32'h1234_5678, 1'b1, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 32'h0000_000B, 1'b1, 1'b1, 16'd5, 16'd2, 32'hA, 32'hB, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'h0,         1'b1, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        // Zero-length header: bad_len, FSM stays in HDR
        add(1'b1, 32'h0000_0000, 1'b1, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 32'h0,         1'b1, 1'b0, 16'd0, 16'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

        // ---------------- reset ----------------
        RST = 1'b0;
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        check_out("reset", 1'b0, 16'd0, 16'd0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        RST = 1'b1;

        // ---------------- apply table ----------------
        foreach (vecs[i]) begin
            step(vecs[i].bv, vecs[i].b, vecs[i].rdy);
            ed = '0;
            ed[31:0]  = vecs[i].w0;
            ed[63:32] = vecs[i].w1;
            check_out($sformatf("row%0d", i), vecs[i].ev, vecs[i].em, vecs[i].en, ed,
                      vecs[i].eb, vecs[i].eo, vecs[i].el, 1'b0);
        end

        // ---------------- test 6: reset mid-message ----------------
        step(1'b1, 32'h0005_0004, 1'b1);
        step(1'b1, 32'h0000_00AA, 1'b1);
        chk("midmsg_busy", DW'(busy), DW'(1'b1));
        RST = 1'b0;
        step(1'b1, 32'h0000_00BB, 1'b1);
        check_out("midreset", 1'b0, 16'd0, 16'd0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        RST = 1'b1;
        step(1'b1, 32'h0006_0002, 1'b1);
        check_out("fresh_hdr", 1'b0, 16'd0, 16'd0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0055, 1'b1);
        ed = '0;
        ed[31:0] = 32'h55;
        check_out("fresh_msg", 1'b1, 16'd6, 16'd1, ed, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        chk("fresh_drain", DW'(msg_valid), DW'(1'b0));

        // ---------------- maximum legal length (L = MAX_WORDS+1) ----------------
        step(1'b1, 32'h000A_0011, 1'b1);
        chk("max_hdr_busy", DW'(busy), DW'(1'b1));
        ed = '0;
        for (int w = 0; w < MW; w++) begin
            step(1'b1, 32'h0000_0100 + 32'(w), 1'b1);
            ed[32*w +: 32] = 32'h0000_0100 + 32'(w);
            if (w < MW - 1) begin
                chk($sformatf("max_mid%0d_valid", w), DW'(msg_valid), DW'(1'b0));
            end
        end
        check_out("max_msg", 1'b1, 16'h000A, 16'd16, ed, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1);

        // ---------------- L = MAX_WORDS+2: just too long ----------------
        step(1'b1, 32'h000B_0012, 1'b1);
        check_out("over18_hdr", 1'b0, 16'd0, 16'd0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int w = 0; w < 17; w++) begin
            step(1'b1, 32'h0000_0200 + 32'(w), 1'b1);
        end
        check_out("over18_end", 1'b0, 16'd0, 16'd0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // ---------------- test 4: L = 20 discarded, then a good message ----------------
        step(1'b1, 32'h0001_0014, 1'b1);
        chk("over20_busy", DW'(busy), DW'(1'b1));
        for (int w = 0; w < 19; w++) begin
            step(1'b1, 32'h0000_0300 + 32'(w), 1'b1);
            chk($sformatf("over20_b%0d_valid", w), DW'(msg_valid), DW'(1'b0));
        end
        chk("over20_end_busy", DW'(busy), DW'(1'b0));
        step(1'b1, 32'h0002_0002, 1'b1);
        step(1'b1, 32'h0000_CAFE, 1'b1);
        ed = '0;
        ed[31:0] = 32'h0000_CAFE;
        check_out("after_over", 1'b1, 16'd2, 16'd1, ed, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        chk("after_over_drain", DW'(msg_valid), DW'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
